// File: rtl/qar_dmem_responder.sv
// qar_dmem_responder: request/ready data-memory responder for the QAR core load/store port.
// Latency: the array is accessed WAIT_STATES+1 cycles after accept, and mem_ready pulses in the following cycle.
// Backpressure: nothing is queued; mem_req is sampled only in IDLE, so a request that is not accepted stays pending at the core.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   mem_req                request valid, sampled only in IDLE
//   mem_addr, mem_wdata    byte address and store data, latched at accept
//   mem_we                 1 = store, 0 = load, latched at accept
//   mem_rdata              registered load data; holds the last load result
//   mem_ready              one-cycle completion pulse, registered
//   mem_err                access error, valid with mem_ready
//
// Build option: define QAR_DMEM_ERR_EN to flag misaligned and out-of-range accesses.
// When it is undefined, the word index wraps modulo DEPTH_WORDS and mem_err stays 0.
module qar_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // WAIT covers WAIT_STATES cycles, so the counter starts one below the count.
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [AW-1:0] idx;
  logic          acc_err;
  logic          accept;
  logic [31:0]   mem [DEPTH_WORDS];

  assign accept = (state == S_IDLE) && mem_req;

`ifdef QAR_DMEM_ERR_EN
  // The full address is kept so the error check can see the low and high bits.
  logic [31:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (accept) begin
      addr_q <= mem_addr;
    end
  end

  assign idx     = addr_q[AW+1:2];
  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q >= 32'(4 * DEPTH_WORDS));
`else
  // Only the word-index bits matter. The byte offset and upper bits are dropped.
  logic [AW-1:0] idx_q;
  logic          unused_addr_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= mem_addr[AW+1:2];
    end
  end

  assign idx              = idx_q;
  assign acc_err          = 1'b0;
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (mem_req) state_nxt = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt == 4'd0) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Latched request, wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      if (accept) begin
        wdata_q <= mem_wdata;
        we_q    <= mem_we;
        cnt     <= CNT_INIT;
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if ((state == S_ACCESS) && !we_q && !acc_err) begin
        mem_rdata <= mem[idx];
      end
      // Set on the edge that leaves ACCESS, so the pulse occupies exactly the DONE cycle.
      mem_ready <= (state == S_ACCESS);
      mem_err   <= (state == S_ACCESS) && acc_err;
    end
  end

  // The array has no reset. An aborted transaction never reaches ACCESS, so it never writes.
  always_ff @(posedge clk) begin
    if ((state == S_ACCESS) && we_q && !acc_err) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule
